// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: sync rx, detect start edge, sample bits on generator strobes, buffer one word.
// Latency: start edge -> transaction_en after SYNC_STAGES+1 clk; word and status valid one clk after the stop-bit strobe.
// Backpressure: one-entry valid/ready buffer; a frame finishing while it is full and not drained is dropped and overrun_err pulses.
// Optional parity (parity_en/parity_odd/parity_err ports, PARITY state) is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_deserializer #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              baudrate_clk_en,
    output logic              transaction_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    input  logic              parity_en,
    input  logic              parity_odd,
    output logic              parity_err
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;
    logic                   start_edge;

    logic [DATA_W-1:0]      sh;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   start_ok;
    logic                   data_smp;
    logic                   frame_done;

`ifdef UART_RX_PARITY_EN
    logic                   par_smp;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   perr;
`endif

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_s_d & ~rx_s;

    // Metastability synchronizer on the pad input, idling high, plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: advance only on strobes once a frame is in progress.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) state_nxt = ST_START;
            end
            ST_START: begin
                // A high sample at mid start bit means the edge was a glitch.
                if (baudrate_clk_en) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (baudrate_clk_en && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baudrate_clk_en) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baudrate_clk_en) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decoded per-state strobes and the generator enable.
    always_comb begin
        transaction_en = (state_q != ST_IDLE);
        start_ok       = (state_q == ST_START) && baudrate_clk_en && !rx_s;
        data_smp       = (state_q == ST_DATA) && baudrate_clk_en;
        frame_done     = (state_q == ST_STOP) && baudrate_clk_en;
`ifdef UART_RX_PARITY_EN
        par_smp        = (state_q == ST_PARITY) && baudrate_clk_en;
`endif
    end

    // Right-shift assembly: the first data bit ends up in sh[0] after DATA_W samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (start_ok) begin
            bit_cnt <= '0;
        end else if (data_smp) begin
            sh      <= {rx_s, sh[DATA_W-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mode is frozen at the start bit; the parity sample is checked against the assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            perr      <= 1'b0;
        end else if (start_ok) begin
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            perr      <= 1'b0;
        end else if (par_smp) begin
            perr      <= rx_s ^ (^sh) ^ par_odd_q;
        end
    end
`endif

    // One-entry output buffer: load when empty or draining, otherwise drop the frame and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            overrun_err <= frame_done && rx_valid && !rx_ready;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_valid   <= 1'b1;
                rx_data    <= sh;
                frame_err  <= !rx_s;
`ifdef UART_RX_PARITY_EN
                parity_err <= perr;
`endif
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames at 16 clk/bit with a model that predicts outputs from frame timing.
// Latency: model predicts transaction_en rise 3 clk after the pin edge and word delivery on the stop-bit strobe edge.
// Backpressure: rx_ready is driven by the bench to exercise drain, overrun, and drain-in-completion-cycle cases.
module tb_uart_rx_deserializer;

    localparam int DW       = 8;
    localparam int BIT_CLKS = 16;

    logic          clk             = 1'b0;
    logic          rst_n           = 1'b1;
    logic          rx              = 1'b1;
    logic          baudrate_clk_en = 1'b0;
    logic          rx_ready        = 1'b0;
    logic          transaction_en;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;
`ifdef UART_RX_PARITY_EN
    logic          parity_en  = 1'b0;
    logic          parity_odd = 1'b0;
    logic          parity_err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ovr_seen    = 0;

    // Model of the frame currently on the line and of the output buffer.
    int            m_te_on    = 0;
    int            m_te_off   = 0;
    bit            m_complete = 1'b0;
    logic [DW-1:0] m_data     = '0;
    bit            m_ferr     = 1'b0;
    bit            m_perr     = 1'b0;
    bit            e_valid    = 1'b0;
    logic [DW-1:0] e_data     = '0;
    bit            e_ferr     = 1'b0;
    bit            e_perr     = 1'b0;
    bit            e_ovr      = 1'b0;
    bit            fire;
    bit            rdy_pulse  = 1'b0;

    uart_rx_deserializer #(
        .DATA_W      (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .baudrate_clk_en (baudrate_clk_en),
        .transaction_en  (transaction_en),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .frame_err       (frame_err),
        .overrun_err     (overrun_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_en       (parity_en),
        .parity_odd      (parity_odd),
        .parity_err      (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // RX-mode baud generator: first strobe half a bit after transaction_en rises, then every bit.
    initial begin : baud_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!transaction_en) begin
                cnt             = 0;
                baudrate_clk_en = 1'b0;
            end else begin
                cnt++;
                baudrate_clk_en = (cnt >= 8) && (((cnt - 8) % BIT_CLKS) == 0);
            end
        end
    end

    // Model: buffer rules evaluated at each edge; the frame completes on the predicted stop-strobe edge.
    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) cyc++;
            if (!rst_n) begin
                e_valid    = 1'b0;
                e_data     = '0;
                e_ferr     = 1'b0;
                e_perr     = 1'b0;
                e_ovr      = 1'b0;
                m_te_off   = 0;
                m_complete = 1'b0;
            end else begin
                fire  = m_complete && (cyc == m_te_off);
                e_ovr = fire && e_valid && !rx_ready;
                if (fire && (!e_valid || rx_ready)) begin
                    e_valid = 1'b1;
                    e_data  = m_data;
                    e_ferr  = m_ferr;
                    e_perr  = m_perr;
                end else if (e_valid && rx_ready) begin
                    e_valid = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("transaction_en", 32'(transaction_en), 32'((cyc >= m_te_on) && (cyc < m_te_off)));
            chk("rx_valid", 32'(rx_valid), 32'(e_valid));
            chk("overrun_err", 32'(overrun_err), 32'(e_ovr));
            if (overrun_err) ovr_seen++;
            if (e_valid) begin
                chk("rx_data", 32'(rx_data), 32'(e_data));
                chk("frame_err", 32'(frame_err), 32'(e_ferr));
`ifdef UART_RX_PARITY_EN
                chk("parity_err", 32'(parity_err), 32'(e_perr));
`endif
            end
        end
    end

    task automatic bit_period(input logic v);
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(negedge clk);
            rx = v;
            if (rdy_pulse) rx_ready = (cyc == m_te_off - 1);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit par_on, input bit par_bit,
                              input bit stop_val, input bit abort);
        int k;
        @(negedge clk);
        rx         = 1'b0;
        k          = DW + 1 + (par_on ? 1 : 0);
        m_te_on    = cyc + 3;
        m_te_off   = abort ? 32'h7fff_ffff : cyc + 11 + BIT_CLKS * k;
        m_complete = !abort;
        m_data     = d;
        m_ferr     = !stop_val;
`ifdef UART_RX_PARITY_EN
        m_perr     = par_on && (par_bit != ((^d) ^ parity_odd));
`else
        m_perr     = 1'b0;
`endif
        repeat (BIT_CLKS - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            if (abort && i == 4) begin
                @(negedge clk);
                rx = d[i];
                repeat (7) @(negedge clk);
                return;
            end
            bit_period(d[i]);
        end
        if (par_on) bit_period(par_bit);
        bit_period(stop_val);
    endtask

    task automatic glitch();
        @(negedge clk);
        rx         = 1'b0;
        m_te_on    = cyc + 3;
        m_te_off   = cyc + 11;
        m_complete = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " transaction_en"}, 32'(transaction_en), 32'd0);
        chk({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, " rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, " frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, " overrun_err"}, 32'(overrun_err), 32'd0);
`ifdef UART_RX_PARITY_EN
        chk({tag, " parity_err"}, 32'(parity_err), 32'd0);
`endif
    endtask

    initial begin : stim
        int o0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("A5 rx_data", 32'(rx_data), 32'hA5);
        chk("A5 rx_valid", 32'(rx_valid), 32'd1);
        chk("A5 frame_err", 32'(frame_err), 32'd0);
        chk("A5 transaction_en", 32'(transaction_en), 32'd0);
        drain();
        repeat (4) @(negedge clk);

        // 0x3C with low stop bit, then line held low (break)
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("3C rx_data", 32'(rx_data), 32'h3C);
        chk("3C frame_err", 32'(frame_err), 32'd1);
        chk("break transaction_en", 32'(transaction_en), 32'd0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        drain();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("after break rx_data", 32'(rx_data), 32'h96);
        chk("after break frame_err", 32'(frame_err), 32'd0);
        drain();
        repeat (4) @(negedge clk);

        // 4-cycle glitch
        glitch();
        repeat (30) @(negedge clk);
        chk("glitch rx_valid", 32'(rx_valid), 32'd0);
        chk("glitch transaction_en", 32'(transaction_en), 32'd0);

        // Overrun: 0x11 then 0x22 with nobody reading
        o0 = ovr_seen;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("overrun rx_data", 32'(rx_data), 32'h11);
        chk("overrun pulses", 32'(ovr_seen - o0), 32'd1);
        drain();
        repeat (4) @(negedge clk);

        // Drain in the completion cycle: new word replaces old, no overrun
        o0 = ovr_seen;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        rdy_pulse = 1'b1;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        rdy_pulse = 1'b0;
        rx_ready  = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain-at-done rx_data", 32'(rx_data), 32'h22);
        chk("drain-at-done rx_valid", 32'(rx_valid), 32'd1);
        chk("drain-at-done overrun", 32'(ovr_seen - o0), 32'd0);
        drain();
        repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07: correct parity bit is 1
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par ok rx_data", 32'(rx_data), 32'h07);
        chk("par ok parity_err", 32'(parity_err), 32'd0);
        drain();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par bad parity_err", 32'(parity_err), 32'd1);
        chk("par bad frame_err", 32'(frame_err), 32'd0);
        drain();
        parity_en = 1'b0;
        repeat (4) @(negedge clk);
`endif

        // Reset during data bit 4, then a clean frame
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        #3;
        rx    = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midframe reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("post-reset rx_data", 32'(rx_data), 32'h5A);
        chk("post-reset rx_valid", 32'(rx_valid), 32'd1);
        chk("post-reset frame_err", 32'(frame_err), 32'd0);
        drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receive datapath stage that pairs with the RX-mode baud-rate generator. It detects a start bit on the serial line and raises `transaction_en` so the generator produces mid-bit sample strobes. On each `baudrate_clk_en` strobe it samples one bit, assembles a frame, and presents the received word through a one-entry valid/ready output buffer. It sits between the pad-level `rx` pin and the peripheral's RX FIFO.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `SYNC_STAGES`, 2: synchronizer flops on `rx`; minimum 2.
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line; idles high; asynchronous to `clk`.
- `baudrate_clk_en`  input  1  one-cycle sample strobe from the generator in RX mode.
  - The first strobe arrives about half a bit after `transaction_en` rises.
  - Later strobes arrive every full bit period.
- `transaction_en`  output  1  frame-in-progress flag; also enables the generator.
- `rx_data`  output  DATA_W  received word; LSB is received first.
- `rx_valid`  output  1  `rx_data` and the status bits are valid.
- `rx_ready`  input  1  consumer accepts the word when `rx_valid && rx_ready`.
- `frame_err`  output  1  stop bit was sampled low; qualified by `rx_valid`.
- `overrun_err`  output  1  one-cycle pulse: a completed frame was dropped because the buffer was full.
- `parity_en`  input  1  parity bit present (only with the macro).
- `parity_odd`  input  1  1 = odd parity, 0 = even parity (only with the macro).
- `parity_err`  output  1  parity mismatch; qualified by `rx_valid` (only with the macro).

## Operation
- `rx` passes through `SYNC_STAGES` flops, each reset to 1, to give `rx_s`. A registered copy `rx_s_d` is kept for edge detection.
- State machine states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `transaction_en` = 0.
  - On `rx_s_d==1 && rx_s==0`: set `transaction_en` = 1 and go to START.
- START, on strobe:
  - `rx_s==0`: clear `bit_cnt` and go to DATA.
  - `rx_s==1`: treat as a glitch or false start; go to IDLE with `transaction_en` = 0. No output is produced.
- DATA, on strobe:
  - Shift `rx_s` in at the MSB of shift register `sh` (right shift), so after DATA_W bits the first-received bit lands at `sh[0]`.
  - `bit_cnt` counts 0..DATA_W-1 and is `$clog2(DATA_W)` wide.
  - At `bit_cnt==DATA_W-1`: go to PARITY if parity is enabled, otherwise to STOP.
- PARITY, on strobe:
  - Compute expected = XOR of `sh` XOR `parity_odd`.
  - `perr` = `rx_s` != expected.
  - Go to STOP.
- STOP, on strobe:
  - `ferr` = !`rx_s`.
  - Complete the frame, then go to IDLE with `transaction_en` = 0.
  - The remaining half stop bit is idle time; a new start edge may be detected from then on.
  - After a break (line held low), no new frame starts until `rx_s` returns high and falls again.
- Frame completion, buffer empty or being drained (`!rx_valid || rx_ready` in the same cycle):
  - Load `rx_data` = `sh`, `frame_err`, and `parity_err`; set `rx_valid` = 1.
- Frame completion, buffer full and not accepted:
  - Keep the old word and drop the new one.
  - Pulse `overrun_err` for 1 cycle.
- `rx_valid` clears when `rx_valid && rx_ready` and no frame completes in that cycle.
- Strobes in IDLE are ignored. Between strobes the state machine holds.
- `parity_en` and `parity_odd` are sampled at START and held for the frame; changes mid-frame do not apply until the next frame.

## Timing
- Reset values:
  - Outputs: `transaction_en`=0, `rx_valid`=0, `rx_data`=0, `frame_err`=0, `parity_err`=0, `overrun_err`=0.
  - Internal: state=IDLE.
  - Reset mid-frame aborts the frame with no output.
- `rx` falling at the pin → `transaction_en` high after SYNC_STAGES+1 clk edges.
- STOP strobe at edge N → `rx_valid`, `rx_data`, and errors updated at edge N+1. `transaction_en` falls at edge N+1.
- `overrun_err` is asserted only in cycle N+1.
- The handshake completes on any edge where `rx_valid && rx_ready`. `rx_ready` may be high while `rx_valid` is low, with no effect.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the `parity_en`, `parity_odd`, and `parity_err` ports and the PARITY state exist.
  - Undefined: those ports and the state are absent; DATA goes straight to STOP.

## Test plan
- 8N1 frame 0xA5 at 16 clk/bit, strobes at mid-bit → `rx_data`=0xA5, `rx_valid`=1, `frame_err`=0; `transaction_en` low after STOP.
- Stop bit driven low on 0x3C → `rx_data`=0x3C, `frame_err`=1. A new frame is accepted only after the line returns high.
- 4-cycle low glitch, sampled high at START → no `rx_valid`; back in IDLE with `transaction_en`=0.
- Two frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun_err` pulses for one cycle. With `rx_ready`=1 in the completion cycle instead → `rx_data`=0x22 and no overrun.
- With the macro: `parity_en`=1, `parity_odd`=0, data 0x07 with parity bit 1 → `parity_err`=0. With parity bit 0 → `parity_err`=1.
- `rst_n` asserted during DATA bit 4 → all outputs 0 immediately. The next clean frame 0x5A is received correctly.
